// File: rtl/cmp_lgez_serial.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_lgez_serial
//  Description : Chunk-serial LGEZ comparator. Two wide operands arrive
//                MSB-first as p_CHUNK-bit chunks over a valid/ready stream
//                and are reduced to the 2-bit {rx, ry} code:
//                00 equal/zero, 01 x<y, 10 x>y, 11 equal/nonzero.
//                Optional macro CMP_LGEZ_SERIAL_EARLY_EN: finish the
//                operation on the first deciding chunk instead of always
//                consuming all p_CHUNKS chunks.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_lgez_serial #(
  parameter int p_CHUNK  = 4,
  parameter int p_CHUNKS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic [p_CHUNK-1:0] i_x,
  input  logic [p_CHUNK-1:0] i_y,
  output logic               o_ready,
  output logic               o_rx,
  output logic               o_ry,
  output logic               o_done
);

  localparam int                 c_CNT_W = $clog2(p_CHUNKS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(p_CHUNKS - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_decided;
  logic               r_nonzero;
  logic [1:0]         r_code;
  logic               r_rx;
  logic               r_ry;

  logic               w_xfer;
  logic               w_begin;
  logic               w_gt;
  logic               w_lt;
  logic               w_early;
  logic               w_dec_nxt;
  logic               w_nz_nxt;
  logic [1:0]         w_code_nxt;
  logic [1:0]         w_result;

  assign w_xfer  = i_valid && (r_state == S_RUN);
  // A new operation may only be launched between operations.
  assign w_begin = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_gt    = (i_x > i_y);
  assign w_lt    = (i_x < i_y);

`ifdef CMP_LGEZ_SERIAL_EARLY_EN
  // The first differing chunk fixes the answer, so stop accepting chunks.
  assign w_early = !r_decided && (w_gt || w_lt);
`else
  assign w_early = 1'b0;
`endif

  // Fold the current chunk into the running decision (first difference wins).
  always_comb begin
    w_dec_nxt  = r_decided;
    w_code_nxt = r_code;
    w_nz_nxt   = r_nonzero;
    if (!r_decided) begin
      if (w_gt) begin
        w_code_nxt = 2'b10;
        w_dec_nxt  = 1'b1;
      end else if (w_lt) begin
        w_code_nxt = 2'b01;
        w_dec_nxt  = 1'b1;
      end else if (i_x != '0) begin
        w_nz_nxt = 1'b1;
      end
    end
    if (w_dec_nxt) begin
      w_result = w_code_nxt;
    end else begin
      w_result = w_nz_nxt ? 2'b11 : 2'b00;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_xfer && ((r_cnt == c_LAST) || w_early)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = i_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-operation accumulators: cleared on launch, advanced on each transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_nonzero <= 1'b0;
      r_code    <= 2'b00;
    end else if (w_begin) begin
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_nonzero <= 1'b0;
      r_code    <= 2'b00;
    end else if (w_xfer) begin
      r_cnt     <= r_cnt + c_ONE;
      r_decided <= w_dec_nxt;
      r_nonzero <= w_nz_nxt;
      r_code    <= w_code_nxt;
    end
  end

  // Result register: loaded only on the transfer that enters DONE, then held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx <= 1'b0;
      r_ry <= 1'b0;
    end else if (w_xfer && (w_state_nxt == S_DONE)) begin
      r_rx <= w_result[1];
      r_ry <= w_result[0];
    end
  end

  assign o_ready = (r_state == S_RUN);
  assign o_done  = (r_state == S_DONE);
  assign o_rx    = r_rx;
  assign o_ry    = r_ry;

endmodule
`default_nettype wire

// File: tb/tb_cmp_lgez_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_lgez_serial
//  Description : Self-checking bench for cmp_lgez_serial. A whole-operand
//                arithmetic model predicts ready/done/code every cycle;
//                directed cases pin literal results, then random operations
//                with stalls, stray starts and back-to-back launches.
//                Honours CMP_LGEZ_SERIAL_EARLY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_lgez_serial;

  localparam int CH = 4;
  localparam int N  = 4;
  localparam int W  = CH * N;
`ifdef CMP_LGEZ_SERIAL_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic [CH-1:0] i_x = '0;
  logic [CH-1:0] i_y = '0;
  logic          o_ready, o_rx, o_ry, o_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  cmp_lgez_serial #(.p_CHUNK(CH), .p_CHUNKS(N)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(i_start),
    .i_valid(i_valid),
    .i_x    (i_x),
    .i_y    (i_y),
    .o_ready(o_ready),
    .o_rx   (o_rx),
    .o_ry   (o_ry),
    .o_done (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Whole-operand LGEZ rule.
  function automatic logic [1:0] lgez(input logic [63:0] a, input logic [63:0] b);
    if (a > b) return 2'b10;
    if (a < b) return 2'b01;
    return (a != 0) ? 2'b11 : 2'b00;
  endfunction

  // Number of chunks the block should consume for an operand pair.
  function automatic int exp_xfers(input logic [W-1:0] x, input logic [W-1:0] y);
    if (!EARLY) return N;
    for (int k = 0; k < N; k++)
      if (x[W-1-k*CH -: CH] != y[W-1-k*CH -: CH]) return k + 1;
    return N;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_phase = 0;   // 0 idle, 1 collecting chunks, 2 result cycle
  int          m_n = 0;
  logic [63:0] m_x = '0, m_y = '0;
  logic [1:0]  exp_code = 2'b00;
  logic [63:0] nx, ny;
  assign nx = (m_x << CH) | 64'(i_x);
  assign ny = (m_y << CH) | 64'(i_y);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_n <= 0; m_x <= '0; m_y <= '0; exp_code <= 2'b00;
    end else begin
      case (m_phase)
        0: if (i_start) begin m_phase <= 1; m_n <= 0; m_x <= '0; m_y <= '0; end
        1: if (i_valid) begin
             m_x <= nx; m_y <= ny; m_n <= m_n + 1;
             if ((m_n + 1 == N) || (EARLY && (nx != ny))) begin
               exp_code <= lgez(nx, ny);
               m_phase  <= 2;
             end
           end
        default: begin
          if (i_start) begin m_phase <= 1; m_n <= 0; m_x <= '0; m_y <= '0; end
          else m_phase <= 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", o_ready, (m_phase == 1));
      check("cyc_done",  o_done,  (m_phase == 2));
      check("cyc_code",  {o_rx, o_ry}, exp_code);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_op();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("run_entry", o_ready, 1);
  endtask

  task automatic send_chunks(input logic [W-1:0] x, input logic [W-1:0] y,
                             input int stall_at, input int stall_len,
                             input int start_at, output int nxfer);
    nxfer = 0;
    for (int k = 0; k < N; k++) begin
      if (k == stall_at) begin
        i_valid = 1'b0;
        repeat (stall_len) begin @(posedge clk); #1; end
      end
      i_valid = 1'b1;
      i_x     = x[W-1-k*CH -: CH];
      i_y     = y[W-1-k*CH -: CH];
      i_start = (k == start_at);
      @(posedge clk); #1;
      nxfer++;
      i_start = 1'b0;
      if (!o_ready) break;
    end
    i_valid = 1'b0;
  endtask

  // Called #1 after the final transfer edge: the pulse must be visible now.
  task automatic check_done(input string name, input logic [1:0] exp, input bit hold);
    check({name, "_done"}, o_done, 1);
    check({name, "_code"}, {o_rx, o_ry}, exp);
    i_start = hold;
    @(posedge clk); #1;
    i_start = 1'b0;
    check({name, "_pulse"}, o_done, 0);
    check({name, "_hold"}, {o_rx, o_ry}, exp);
    check({name, "_next"}, o_ready, hold);
  endtask

  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [1:0] exp, input int stall_at, input int stall_len);
    int nx_;
    begin_op();
    send_chunks(x, y, stall_at, stall_len, -1, nx_);
    check({name, "_xfers"}, nx_, exp_xfers(x, y));
    check_done(name, exp, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int nxf;
    logic [W-1:0] rx_, ry_;
    bit hold;
    @(posedge clk); #1;
    check("rst_ready", o_ready, 0);
    check("rst_done",  o_done,  0);
    check("rst_code",  {o_rx, o_ry}, 2'b00);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("zero",  16'h0000, 16'h0000, 2'b00, -1, 0);
    directed("lt",    16'h1234, 16'h1235, 2'b01, -1, 0);
    directed("gt",    16'hF000, 16'h0FFF, 2'b10, -1, 0);
    directed("eqnz",  16'hA5A5, 16'hA5A5, 2'b11, -1, 0);
    directed("stall", 16'h00F0, 16'h00F0, 2'b11,  2, 3);
    check("model_pin", exp_code, 2'b11);

    // Reset in the middle of an operation.
    begin_op();
    i_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_x = 4'(16'h8000 >> (W - CH - k*CH));
      i_y = 4'(16'h0001 >> (W - CH - k*CH));
      @(posedge clk); #1;
      if (!o_ready) break;
    end
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_code",  {o_rx, o_ry}, 2'b00);
    check("arst_ready", o_ready, 0);
    check("arst_done",  o_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_nodone", o_done, 0);
    end

    // Fresh operation, then back-to-back launch held at DONE with a stray start in RUN.
    begin_op();
    send_chunks(16'h0001, 16'h8000, -1, 0, -1, nxf);
    check_done("fresh", 2'b01, 1'b1);
    send_chunks(16'h0003, 16'h0002, -1, 0, 1, nxf);
    check("b2b_xfers", nxf, N);
    check_done("b2b", 2'b10, 1'b0);

    directed("early", 16'h9000, 16'h1000, 2'b10, -1, 0);
    check("early_len", exp_xfers(16'h9000, 16'h1000), EARLY ? 1 : 4);

    // Randomised operations.
    hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rx_ = W'($urandom);
      case ($urandom_range(0, 3))
        0:       ry_ = rx_;
        1:       ry_ = rx_ ^ (W'(1) << $urandom_range(0, W - 1));
        2:       ry_ = W'($urandom);
        default: begin rx_ = '0; ry_ = '0; end
      endcase
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        begin_op();
      end
      send_chunks(rx_, ry_, int'($urandom_range(0, N + 2)), int'($urandom_range(1, 3)),
                  int'($urandom_range(0, N + 2)), nxf);
      check("rnd_xfers", nxf, exp_xfers(rx_, ry_));
      hold = (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
      check_done("rnd", lgez(64'(rx_), 64'(ry_)), hold);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
